data_mem_if: RTL
================

// Module: data_mem_if
// PURPOSE
//   Load/store bus interface directly downstream of the single-cycle datapath.
//   Accepts ALUResult (address), WriteData and MemWrite/MemRead from the datapath/controller.
//   Runs a req/ack transaction on an external memory bus and returns ReadData.
//   Asserts Stall so the core freezes the PC and register writes until the access completes.
//   Also detects misaligned accesses and bus timeouts, and reports them on MemFault.
// PARAMETERS
//   DATA_W    32   data/address width
//   TIMEOUT   255  max BUSY cycles before abort (1..2^CNT_W-1)
//   CNT_W     8    timeout counter width
// PORTS
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous, active-low reset (0 = reset)
//   MemRead    in   1       load request for the current instruction
//   MemWrite   in   1       store request for the current instruction
//   ALUResult  in   DATA_W  byte address
//   WriteData  in   DATA_W  store data
//   ReadData   out  DATA_W  load data; valid in the DONE cycle
//   Stall      out  1       1 = hold PC/regfile this cycle
//   MemFault   out  1       1-cycle pulse: misaligned access or timeout
//   bus_req    out  1       transaction request, held until ack
//   bus_we     out  1       1 = write
//   bus_addr   out  DATA_W  word-aligned address, stable while bus_req=1
//   bus_wdata  out  DATA_W  write data, stable while bus_req=1
//   bus_ack    in   1       slave accepts/completes; sampled only while bus_req=1
//   bus_rdata  in   DATA_W  read data, valid when bus_ack=1 and bus_we=0
// BEHAVIOUR
//   Reset (reset=0, async)
//     state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
//     ReadData=0, MemFault=0, counter=0.
//     Reset mid-transaction drops bus_req immediately; the access is abandoned, not retried.
//   States: IDLE, BUSY, DONE
//   IDLE
//     acc = MemRead|MemWrite. If both are set, it is a write (MemWrite wins).
//     acc & ALUResult[1:0]==0:
//       Stall=1 (combinational).
//       Latch addr, wdata, we=MemWrite.
//       bus_req=1 from the next cycle; go to BUSY; counter=0.
//     acc & misaligned:
//       No bus cycle; Stall=0.
//       MemFault=1 next cycle (registered); ReadData=0.
//       Remain IDLE.
//     !acc: Stall=0; remain IDLE.
//   BUSY
//     Stall=1; bus_req=1; bus_addr/bus_we/bus_wdata held constant.
//     bus_ack=1: capture bus_rdata into ReadData (a write captures 0); go to DONE; bus_req=0 next cycle.
//     Else counter++. When counter==TIMEOUT-1 without ack: ReadData=0, MemFault=1 in DONE, go to DONE.
//     An ack in the same cycle as the timeout is treated as success; the ack wins.
//   DONE
//     Stall=0 so the core retires the instruction at this edge.
//     ReadData is valid for this cycle.
//     Mem inputs are ignored in this cycle; go to IDLE unconditionally.
//   Latency: a zero-wait slave (ack in the first BUSY cycle) gives Stall=1 for 2 cycles.
//     A load/store occupies 3 cycles.
//     Each extra wait cycle adds 1.
//   ReadData holds its last value except when it is updated.
//   MemFault is 0 except in the single pulse cycles above.
//   Counter saturates and never wraps; it is cleared on entry to BUSY.
// STRUCTURE
//   Shared package: state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
//     Also FAULT_MISALIGN / FAULT_TIMEOUT codes for future cause logging.
//   Sub-module: timeout_counter (CNT_W, sync clear, enable, saturating, terminal-count out).
//   Registers use the existing flop style with an async active-low reset.
// TESTING
//   1. Load 0x100, slave acks in the 1st BUSY cycle with rdata=0xCAFE0001
//      -> Stall high 2 cycles; ReadData=0xCAFE0001 in DONE; bus_we=0.
//   2. Store 0x0000_0204, WriteData=0x12345678, ack after 3 waits
//      -> bus_addr/bus_wdata stable for 4 BUSY cycles; Stall=1 for 5 cycles; bus_we=1.
//   3. Load at 0x102 (misaligned)
//      -> bus_req stays 0; Stall=0; MemFault pulses 1 cycle; ReadData=0.
//   4. No ack with TIMEOUT=4
//      -> bus_req high for 4 cycles, then 0; MemFault=1 and ReadData=0 in DONE; back to IDLE.
//   5. MemRead=MemWrite=1 at 0x10 -> bus_we=1 (write wins).
//   6. reset=0 asserted in the 2nd BUSY cycle
//      -> bus_req=0 in the same cycle (async); after release, IDLE and no stale ack is captured.

Source files
------------

// File: rtl/data_mem_if_pkg.sv
// Shared definitions for the load/store bus interface: FSM state codes,
// fault cause codes and a small alignment helper.
package data_mem_if_pkg;

  // Legacy-compatible state encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Fault cause codes, reserved for cause logging
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_TIMEOUT  = 2'd2
  } fault_e;

  // A word access is aligned when the two byte-offset bits are zero
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_if_timeout_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// tc flags that the count currently equals TERMINAL.
module timeout_counter #(
  parameter int unsigned          CNT_W    = 8,
  parameter logic [CNT_W-1:0]     TERMINAL = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  // Count while enabled; clear has priority; stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == TERMINAL);

endmodule

// File: rtl/data_mem_if.sv
// Load/store bus interface sitting after the single-cycle datapath.
// Turns MemRead/MemWrite into a req/ack bus transaction, stalls the core
// until it completes, and flags misaligned accesses and bus timeouts.
module data_mem_if
  import data_mem_if_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              MemFault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  logic [1:0] state;
  logic       acc;
  logic       start;
  logic       misalign;
  logic       tmo_tc;

  // Request decode in IDLE: aligned accesses start a bus cycle, others fault
  always_comb begin
    acc      = MemRead | MemWrite;
    start    = (state == IDLE) && acc && is_aligned(ALUResult[1:0]);
    misalign = (state == IDLE) && acc && !is_aligned(ALUResult[1:0]);
  end

  // bus_req is decoded from state so an async reset drops it immediately
  assign bus_req = (state == BUSY);
  assign Stall   = start || (state == BUSY);

  timeout_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (CNT_W'(TIMEOUT - 1))
  ) u_tmo (
    .clk   (clk),
    .rst_n (reset),
    .clr   (start),
    .en    ((state == BUSY) && !bus_ack),
    .tc    (tmo_tc)
  );

  // Transaction FSM, bus latches, read data and fault pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      ReadData  <= '0;
      MemFault  <= 1'b0;
    end else begin
      MemFault <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bus_addr  <= {ALUResult[DATA_W-1:2], 2'b00};
            bus_wdata <= WriteData;
            bus_we    <= MemWrite;
            state     <= BUSY;
          end else if (misalign) begin
            MemFault <= 1'b1;
            ReadData <= '0;
          end
        end
        BUSY: begin
          // ack is checked first so an ack on the timeout cycle succeeds
          if (bus_ack) begin
            ReadData <= bus_we ? '0 : bus_rdata;
            state    <= DONE;
          end else if (tmo_tc) begin
            ReadData <= '0;
            MemFault <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
